// File: rtl/pacman_pkg.sv
// Pac-Man sprite renderer shared types: facing, sprite geometry, colour indices, palette.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pacman_pkg;

  // Facing as seen by the rest of the game; the stored sprite faces right.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  localparam int SPRITE_SIZE = 15;

  // 2-bit colour indices stored in the sprite memory
  localparam logic [1:0] CI_TRANSP = 2'd0;
  localparam logic [1:0] CI_BODY   = 2'd1;
  localparam logic [1:0] CI_MOUTH  = 2'd2;
  localparam logic [1:0] CI_HILITE = 2'd3;

  localparam logic [23:0] YELLOW = 24'hFF_FF_00;
  localparam logic [23:0] WHITE  = 24'hFF_FF_FF;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/sprite_addr_xform.sv
// Maps a sprite-relative (row, col) offset and facing to a sprite memory address.
// Latency: purely combinational.
// Backpressure: none.
// Ports: r/c = 10-bit scan offset from sprite top-left (wrapped), dir = facing,
//        addr = 8-bit sprite memory address (0 when outside the box), in_box = offset lies in sprite.
module sprite_addr_xform
  import pacman_pkg::*;
#(
  parameter int SIZE = SPRITE_SIZE
) (
  input  logic [9:0] r,
  input  logic [9:0] c,
  input  dir_t       dir,
  output logic [7:0] addr,
  output logic       in_box
);

  localparam logic [9:0] EDGE   = 10'(SIZE);
  localparam logic [3:0] LAST   = 4'(SIZE - 1);
  localparam logic [7:0] STRIDE = 8'(SIZE);

  logic [3:0] rn;
  logic [3:0] cn;
  logic [7:0] major;
  logic [7:0] minor;

  // Negative offsets wrap to large unsigned values, so a single compare
  // per axis handles both sides of the box.
  always_comb begin
    in_box = (r < EDGE) && (c < EDGE);
    rn     = r[3:0];
    cn     = c[3:0];
    major  = '0;
    minor  = '0;
    // Left mirrors columns; up/down transpose, with up also flipping rows.
    unique case (dir)
      DIR_RIGHT: begin major = {4'd0, rn}; minor = {4'd0, cn};        end
      DIR_LEFT:  begin major = {4'd0, rn}; minor = {4'd0, LAST - cn}; end
      DIR_UP:    begin major = {4'd0, cn}; minor = {4'd0, LAST - rn}; end
      DIR_DOWN:  begin major = {4'd0, cn}; minor = {4'd0, rn};        end
    endcase
    addr = in_box ? 8'(major * STRIDE + minor) : 8'd0;
  end

endmodule

// File: rtl/pacman_renderer.sv
// Renders Pac-Man: sprite address generation, memory-latency tracking, palette and mouth animation.
// Latency: fixed 3 cycles from DrawX/DrawY to pixel_on/RGB (address registered after 1 cycle).
// Backpressure: none; locked to the scan, one pixel accepted and produced every cycle.
// Ports: Clk/Reset (async, active-high); frame_start = per-frame pulse; DrawX/DrawY = scan position;
//        PacX/PacY/dir/moving = sprite state; sprite_data = memory read data (1-cycle after read_address);
//        read_address -> sprite memory; pixel_on/Red/Green/Blue -> colour mapper.
module pacman_renderer
  import pacman_pkg::*;
#(
  parameter int SPRITE_SIZE = pacman_pkg::SPRITE_SIZE,
  parameter int MOUTH_BIT   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] PacX,
  input  logic [9:0] PacY,
  input  logic [1:0] dir,
  input  logic       moving,
  input  logic [1:0] sprite_data,
  output logic [7:0] read_address,
  output logic       pixel_on,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue
);

  logic [9:0] col_ofs;
  logic [9:0] row_ofs;
  logic [7:0] addr_d;
  logic       in_box_d;

  logic       valid1;
  logic       valid2;
  logic [2:0] mouth_cnt;
  logic       mouth_closed;

  logic       pal_on;
  rgb_t       pal_rgb;
  rgb_t       rgb_q;

  // Stage 0: 10-bit wrapping offsets from the sprite origin
  assign col_ofs = DrawX - PacX;
  assign row_ofs = DrawY - PacY;

  sprite_addr_xform #(
    .SIZE(SPRITE_SIZE)
  ) u_xform (
    .r      (row_ofs),
    .c      (col_ofs),
    .dir    (dir_t'(dir)),
    .addr   (addr_d),
    .in_box (in_box_d)
  );

  // Stage 1 (address to memory) and stage 2 (valid tracks memory read latency)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= '0;
      valid1       <= 1'b0;
      valid2       <= 1'b0;
    end else begin
      read_address <= addr_d;
      valid1       <= in_box_d;
      valid2       <= valid1;
    end
  end

  // Mouth counter; a pixel finishing on the same edge sees the old value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mouth_cnt <= '0;
    end else if (frame_start && moving) begin
      mouth_cnt <= mouth_cnt + 3'd1;
    end
  end

  assign mouth_closed = mouth_cnt[MOUTH_BIT];

  // Palette: transparent and out-of-box pixels both come out black with pixel_on low.
  always_comb begin
    pal_on  = 1'b0;
    pal_rgb = '0;
    if (valid2) begin
      unique case (sprite_data)
        CI_TRANSP: ;
        CI_BODY: begin
          pal_on  = 1'b1;
          pal_rgb = YELLOW;
        end
        CI_MOUTH: begin
          // Wedge is filled in body colour only while the mouth is closed
          if (mouth_closed) begin
            pal_on  = 1'b1;
            pal_rgb = YELLOW;
          end
        end
        CI_HILITE: begin
          pal_on  = 1'b1;
          pal_rgb = WHITE;
        end
      endcase
    end
  end

  // Stage 3: registered colour out
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_on <= 1'b0;
      rgb_q    <= '0;
    end else begin
      pixel_on <= pal_on;
      rgb_q    <= pal_rgb;
    end
  end

  assign Red   = rgb_q.red;
  assign Green = rgb_q.green;
  assign Blue  = rgb_q.blue;

endmodule

// File: tb/tb_pacman_renderer.sv
// Self-checking bench for pacman_renderer with a registered sprite memory model and scoreboard.
// Latency: checks address at +1 cycle and pixel/colour at +3 cycles.
// Backpressure: none.
module tb_pacman_renderer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] PacX;
  logic [9:0] PacY;
  logic [1:0] dir;
  logic       moving;
  logic [1:0] sprite_data = 2'd0;
  logic [7:0] read_address;
  logic       pixel_on;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;

  pacman_renderer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .PacX         (PacX),
    .PacY         (PacY),
    .dir          (dir),
    .moving       (moving),
    .sprite_data  (sprite_data),
    .read_address (read_address),
    .pixel_on     (pixel_on),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue)
  );

  always #5 Clk = ~Clk;

  // Sprite memory model: registered read, optional constant override
  logic [1:0] mem [225];
  logic       ovr_en  = 1'b1;
  logic [1:0] ovr_val = 2'd1;

  always @(posedge Clk) begin
    if (ovr_en) sprite_data <= ovr_val;
    else if (read_address < 8'd225) sprite_data <= mem[read_address];
    else sprite_data <= 2'd0;
  end

  typedef struct {
    logic [7:0] addr;
    logic       inb;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] mcnt = 3'd0;
  logic [7:0] dir_exp [4];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic void addr_model(input logic [9:0] dx, input logic [9:0] dy,
                                     input logic [9:0] px, input logic [9:0] py,
                                     input logic [1:0] d,
                                     output logic [7:0] a, output logic ib);
    int c;
    int r;
    int v;
    c  = (int'(dx) - int'(px)) & 1023;
    r  = (int'(dy) - int'(py)) & 1023;
    ib = (c < 15) && (r < 15);
    case (d)
      2'd0:    v = r * 15 + c;
      2'd1:    v = r * 15 + (14 - c);
      2'd2:    v = c * 15 + (14 - r);
      default: v = c * 15 + r;
    endcase
    a = ib ? 8'(v) : 8'd0;
  endfunction

  // Drive one scan pixel at the current negedge, advance to the next negedge, check.
  task automatic step(input logic [9:0] dx, input logic [9:0] dy,
                      input logic [9:0] px, input logic [9:0] py,
                      input logic [1:0] d, input logic mv, input logic fs);
    exp_t e;
    logic pend;
    logic exp_on;
    logic [23:0] exp_rgb;
    DrawX = dx; DrawY = dy; PacX = px; PacY = py; dir = d; moving = mv; frame_start = fs;
    addr_model(dx, dy, px, py, d, e.addr, e.inb);
    e.idx = ovr_en ? ovr_val : ((e.addr < 8'd225) ? mem[e.addr] : 2'd0);
    q.push_back(e);
    pend = fs && mv;
    @(negedge Clk);
    check_eq("addr", 32'(read_address), 32'(q[q.size()-1].addr));
    if (q.size() == 3) begin
      e = q.pop_front();
      exp_on  = 1'b0;
      exp_rgb = 24'h0;
      if (e.inb) begin
        case (e.idx)
          2'd1: begin exp_on = 1'b1; exp_rgb = 24'hFFFF00; end
          2'd2: if (mcnt[2]) begin exp_on = 1'b1; exp_rgb = 24'hFFFF00; end
          2'd3: begin exp_on = 1'b1; exp_rgb = 24'hFFFFFF; end
          default: ;
        endcase
      end
      check_eq("pixel_on", 32'(pixel_on), 32'(exp_on));
      check_eq("rgb", {8'd0, Red, Green, Blue}, {8'd0, exp_rgb});
    end
    if (pend) mcnt = mcnt + 3'd1;
  endtask

  // Out-of-box pixels drain the pipe before the memory override changes
  task automatic flush();
    for (int i = 0; i < 3; i++) step(10'd0, 10'd0, 10'd500, 10'd400, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] px;
    logic [9:0] py;
    int ox;
    int oy;

    dir_exp[0] = 8'd46; dir_exp[1] = 8'd58; dir_exp[2] = 8'd26; dir_exp[3] = 8'd18;
    for (int i = 0; i < 225; i++) mem[i] = 2'((i * 5 + i / 7) % 4);

    // Reset held with an in-box scan position
    Reset = 1'b1; frame_start = 1'b0; moving = 1'b0; dir = 2'd0;
    DrawX = 10'd107; DrawY = 10'd53; PacX = 10'd100; PacY = 10'd50;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check_eq("rst_addr", 32'(read_address), 32'd0);
      check_eq("rst_on", 32'(pixel_on), 32'd0);
      check_eq("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    end
    Reset = 1'b0;
    q.delete();
    mcnt = 3'd0;

    // First in-box pixel after release; latency 1 for address, 3 for colour
    step(10'd107, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    check_eq("addr_52", 32'(read_address), 32'd52);
    check_eq("rel_on1", 32'(pixel_on), 32'd0);
    step(10'd107, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    check_eq("rel_on2", 32'(pixel_on), 32'd0);
    step(10'd107, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    check_eq("lat3_on", 32'(pixel_on), 32'd1);
    check_eq("lat3_rgb", {8'd0, Red, Green, Blue}, 32'h00FFFF00);

    // Direction transform at c=1, r=3
    for (int d = 0; d < 4; d++) begin
      step(10'd101, 10'd53, 10'd100, 10'd50, 2'(d), 1'b0, 1'b0);
      check_eq("dir_addr", 32'(read_address), 32'(dir_exp[d]));
    end

    // Box boundaries on both axes
    step(10'd99, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    check_eq("oob_x_lo", 32'(read_address), 32'd0);
    step(10'd100, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    step(10'd114, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    step(10'd115, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    check_eq("oob_x_hi", 32'(read_address), 32'd0);
    step(10'd107, 10'd49, 10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
    check_eq("oob_y_lo", 32'(read_address), 32'd0);
    step(10'd107, 10'd50, 10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
    step(10'd107, 10'd64, 10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
    step(10'd107, 10'd65, 10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
    check_eq("oob_y_hi", 32'(read_address), 32'd0);

    // Palette: highlight then transparent
    flush(); ovr_val = 2'd3;
    for (int i = 0; i < 4; i++) step(10'd105, 10'd55, 10'd100, 10'd50, 2'd2, 1'b0, 1'b0);
    flush(); ovr_val = 2'd0;
    for (int i = 0; i < 4; i++) step(10'd105, 10'd55, 10'd100, 10'd50, 2'd3, 1'b0, 1'b0);

    // Mouth animation: pixels every cycle so each pulse coincides with a stage-3 pixel
    flush(); ovr_val = 2'd2;
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < 4; i++) step(10'd106, 10'd56, 10'd100, 10'd50, 2'd0, 1'b1, 1'b0);
      step(10'd106, 10'd56, 10'd100, 10'd50, 2'd0, 1'b1, 1'b1);
    end
    // Advance to closed, then hold with moving low
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) step(10'd106, 10'd56, 10'd100, 10'd50, 2'd1, 1'b1, 1'b0);
      step(10'd106, 10'd56, 10'd100, 10'd50, 2'd1, 1'b1, 1'b1);
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++) step(10'd106, 10'd56, 10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
      step(10'd106, 10'd56, 10'd100, 10'd50, 2'd1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(10'd106, 10'd56, 10'd100, 10'd50, 2'd1, 1'b0, 1'b0);

    // Randomised positions around the sprite, including wrap at the screen edge
    flush(); ovr_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      px = 10'($urandom_range(0, 1023));
      py = 10'($urandom_range(0, 1023));
      ox = int'($urandom_range(0, 20)) - 3;
      oy = int'($urandom_range(0, 20)) - 3;
      step(10'(int'(px) + ox), 10'(int'(py) + oy), px, py, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    // Reset mid-pipe: in-flight opaque pixels must never emerge
    flush(); ovr_en = 1'b1; ovr_val = 2'd1;
    for (int i = 0; i < 3; i++) step(10'd107, 10'd53, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
    frame_start = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check_eq("mid_rst_on", 32'(pixel_on), 32'd0);
    check_eq("mid_rst_addr", 32'(read_address), 32'd0);
    check_eq("mid_rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    @(negedge Clk);
    check_eq("mid_rst_hold", 32'(pixel_on), 32'd0);
    DrawX = 10'd0; DrawY = 10'd0;
    @(negedge Clk);
    Reset = 1'b0;
    q.delete();
    mcnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step(10'd0, 10'd0, 10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
      check_eq("post_rst_on", 32'(pixel_on), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pacman_renderer.md
Name: pacman_renderer

Overview:
- Downstream consumer of the Pac-Man sprite memory.
- Takes the VGA scan position and Pac-Man's position and facing, then generates the sprite read address with the rotation or mirror for that facing.
- Tracks the memory's 1-cycle read latency, maps the 2-bit colour index through a palette, and animates the mouth.
- Its outputs feed the colour mapper's priority mux.

Parameters:
- SPRITE_SIZE, 15, sprite edge length in pixels (memory holds SPRITE_SIZE*SPRITE_SIZE = 225 entries).
- MOUTH_BIT, 2, bit of the frame counter that selects mouth closed (toggles every 4 frames).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each vertical blank
- DrawX  in  10  current scan pixel column
- DrawY  in  10  current scan pixel row
- PacX  in  10  sprite top-left column
- PacY  in  10  sprite top-left row
- dir  in  2  facing: 00 right, 01 left, 10 up, 11 down
- moving  in  1  Pac-Man is moving; enables mouth animation
- sprite_data  in  2  colour index returned by the sprite memory
- read_address  out  8  address to the sprite memory
- pixel_on  out  1  sprite pixel is opaque at the aligned scan position
- Red  out  8  red channel for the aligned pixel
- Green  out  8  green channel for the aligned pixel
- Blue  out  8  blue channel for the aligned pixel

Behaviour:
- Reset (asynchronous, active-high) clears every register:
  - read_address=0, pixel_on=0, Red/Green/Blue=0.
  - Valid pipeline bits=0; mouth counter=0 (mouth open).
- Reset asserted mid-operation discards any in-flight pixels. pixel_on falls immediately and stays 0 until new pixels traverse the pipe.
- Stage 0 (combinational):
  - c = DrawX-PacX and r = DrawY-PacY, as 10-bit unsigned (modulo 1024) subtraction.
  - in_box = (c<15)&&(r<15). Negative offsets wrap to ≥1009 and are therefore out of box.
- Address transform, base sprite faces right:
  - right: r*15+c
  - left: r*15+(14-c)
  - up: c*15+(14-r)
  - down: c*15+r
  - Result is always 0..224. When in_box=0, the address is forced to 0.
- Stage 1: read_address and valid1=in_box are registered on Clk. Visible at cycle n+1 for a DrawX/DrawY presented at cycle n.
- Stage 2: the sprite memory returns sprite_data at n+2; valid2 <= valid1.
- Stage 3: palette lookup registered; pixel_on/RGB are valid at n+3. Total latency is 3 cycles and is fixed; the colour mapper delays its own inputs to match.
- Palette:
  - 0 → transparent.
  - 1 → body yellow FF,FF,00.
  - 2 → mouth wedge: yellow when mouth closed, transparent when open.
  - 3 → highlight white FF,FF,FF.
  - Transparent → pixel_on=0 and RGB=0. Out of box → pixel_on=0 and RGB=0.
- Mouth counter:
  - 3 bits, increments (wraps 7→0) on frame_start when moving=1; holds when moving=0.
  - mouth_closed = counter[MOUTH_BIT].
- frame_start coincident with a pixel in stage 3: that pixel uses the pre-update counter. The new value applies from the next cycle.
- PacX, PacY and dir are sampled only in stage 0. Changes mid-line affect only subsequent pixels.
- dir uses all four encodings; there is no illegal value.

Decomposition:
- pacman_pkg:
  - dir_t enum (DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN).
  - SPRITE_SIZE.
  - Colour-index constants (CI_TRANSP, CI_BODY, CI_MOUTH, CI_HILITE).
  - 24-bit palette constants (YELLOW, WHITE).
- Sub-module sprite_addr_xform: purely combinational. Maps (r, c, dir) to an 8-bit address and in_box.
- The pipeline, counter and palette stay in pacman_renderer.

Test Plan:
1. Reset:
   - Assert Reset with DrawX/DrawY inside the box → read_address=0, pixel_on=0 and RGB=0 immediately and while held.
   - Deassert → first valid pixel appears 3 cycles after the first in-box input.
2. Address and latency:
   - PacX=100, PacY=50, dir=right, DrawX=107, DrawY=53 → read_address=52 at n+1.
   - Drive sprite_data=1 at n+2 → pixel_on=1, RGB=FF,FF,00 at n+3.
3. Direction transform:
   - PacX=100, PacY=50, DrawX=101, DrawY=53 (c=1, r=3).
   - Expected read_address: right=46, left=58, up=26, down=18.
4. Box boundaries:
   - PacX=100: DrawX=99 (c=1023) → pixel_on=0. DrawX=100 and 114 → in box. DrawX=115 → out of box.
   - Same four cases on DrawY.
   - Out-of-box inputs give read_address=0.
5. Mouth animation:
   - moving=1, sprite_data=2: frame_start pulses 1–3 → pixel_on=0; pulse 4 → pixel_on=1 yellow; pulse 8 → open again.
   - moving=0 plus pulses → state holds.
   - frame_start coincident with a stage-3 pixel → that pixel uses the old state.
6. Palette and reset mid-pipe:
   - sprite_data=3 → white. sprite_data=0 → pixel_on=0.
   - Assert Reset while valid1/valid2 are set → no pixel_on pulse emerges after reset release.
